// File: rtl/tsn_tx_arbiter.sv
// TSN transmit arbiter: one-hot grant held per frame, inter-frame gap, slot guard band.
// Build option: define TSN_ARB_RR_EN for round-robin selection, otherwise strict priority.
module tsn_tx_arbiter #(
  parameter string       PLATFORM     = "xilinx",
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned GUARD_CYCLES = 200,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_test_start,
  input  logic       in_slot_shift,
  input  logic [7:0] in_valid,
  input  logic       in_tx_done,
  output logic [7:0] out_grant,
  output logic [2:0] out_sel,
  output logic       out_busy
);

  localparam int unsigned GUARD_START = SLOT_CYCLES - GUARD_CYCLES;
  localparam logic [7:0]  IFG_LOAD    = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

  if (SLOT_CYCLES == 0 || SLOT_CYCLES > 65535 || GUARD_CYCLES > SLOT_CYCLES ||
      IFG_CYCLES > 255 || PLATFORM == "") begin : g_bad_cfg
    $error("tsn_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, IFG} state_t;

  state_t      state, state_nxt;
  logic [15:0] slot_cnt;
  logic [7:0]  ifg_cnt, ifg_cnt_nxt;
  logic [7:0]  grant_nxt;
  logic [2:0]  sel_nxt;
  logic        busy_nxt;
  logic        guard;
  logic        start_grant;
  logic [2:0]  winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (!in_test_start || in_slot_shift) begin
      slot_cnt <= '0;
    end else if (slot_cnt != '1) begin
      slot_cnt <= slot_cnt + 16'd1;
    end
  end

  // A boundary pulse opens the new slot in the same cycle it arrives.
  assign guard       = !in_slot_shift && ({16'd0, slot_cnt} >= GUARD_START);
  assign start_grant = in_test_start && !guard && (|in_valid);

`ifdef TSN_ARB_RR_EN
  logic [2:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 3'd7;
    end else if (!in_test_start) begin
      rr_ptr <= 3'd7;
    end else if (state == IDLE && start_grant) begin
      rr_ptr <= winner;
    end
  end

  // Offsets 1..8 from the last winner; offset 8 wraps back onto rr_ptr itself.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = rr_ptr + 3'(i);
      if (!found && in_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && in_valid[i]) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_grant) state_nxt = BUSY;
      BUSY:    if (in_tx_done) state_nxt = (IFG_CYCLES == 0) ? IDLE : IFG;
      IFG:     if (ifg_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!in_test_start) state_nxt = IDLE;
  end

  always_comb begin
    grant_nxt   = out_grant;
    sel_nxt     = out_sel;
    busy_nxt    = out_busy;
    ifg_cnt_nxt = ifg_cnt;
    case (state)
      IDLE: begin
        if (start_grant) begin
          grant_nxt = 8'd1 << winner;
          sel_nxt   = winner;
          busy_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if (in_tx_done) begin
          grant_nxt = '0;
          if (IFG_CYCLES == 0) busy_nxt = 1'b0;
          else                 ifg_cnt_nxt = IFG_LOAD;
        end
      end
      IFG: begin
        if (ifg_cnt == '0) busy_nxt = 1'b0;
        else               ifg_cnt_nxt = ifg_cnt - 8'd1;
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
    if (!in_test_start) begin
      grant_nxt   = '0;
      busy_nxt    = 1'b0;
      ifg_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_grant <= '0;
      out_sel   <= '0;
      out_busy  <= 1'b0;
      ifg_cnt   <= '0;
    end else begin
      out_grant <= grant_nxt;
      out_sel   <= sel_nxt;
      out_busy  <= busy_nxt;
      ifg_cnt   <= ifg_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tsn_tx_arbiter.sv
// Directed bench for tsn_tx_arbiter; expectations follow TSN_ARB_RR_EN when defined.
module tb_tsn_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_test_start;
  logic       in_slot_shift;
  logic [7:0] in_valid;
  logic       in_tx_done;
  logic [7:0] out_grant;
  logic [2:0] out_sel;
  logic       out_busy;

  int n_vec = 0;
  int n_err = 0;

  tsn_tx_arbiter #(
    .PLATFORM    ("xilinx"),
    .SLOT_CYCLES (1000),
    .GUARD_CYCLES(200),
    .IFG_CYCLES  (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_test_start(in_test_start),
    .in_slot_shift(in_slot_shift),
    .in_valid     (in_valid),
    .in_tx_done   (in_tx_done),
    .out_grant    (out_grant),
    .out_sel      (out_sel),
    .out_busy     (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs set before step() are held for one cycle; outputs read after it
  // show the registers updated at the end of that cycle.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic restart();
    in_test_start = 1'b0;
    step();
    in_test_start = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_g;
    logic       seen;
    int         gap;

    rst_n = 1'b0; in_test_start = 1'b0; in_slot_shift = 1'b0;
    in_valid = '0; in_tx_done = 1'b0;
    #12;
    check("rst_grant", 16'(out_grant), 16'h00);
    check("rst_sel",   16'(out_sel),   16'h0);
    check("rst_busy",  16'(out_busy),  16'h0);
    step();
    rst_n = 1'b1;
    in_test_start = 1'b1;

    // No requests: nothing granted.
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_grant != '0 || out_busy) seen = 1'b1;
    end
    check("idle_no_grant", 16'(seen), 16'h0);

    in_valid = 8'h04;
    step();
    check("g4_grant", 16'(out_grant), 16'h04);
    check("g4_sel",   16'(out_sel),   16'h2);
    check("g4_busy",  16'(out_busy),  16'h1);

    // Gate closes mid-frame: grant held until tx_done.
    in_valid = 8'h00;
    idle_cycles(5);
    check("hold_grant", 16'(out_grant), 16'h04);
    in_tx_done = 1'b1;
    step();
    in_tx_done = 1'b0;
    check("rel_grant", 16'(out_grant), 16'h00);
    check("rel_busy",  16'(out_busy),  16'h1);
    idle_cycles(13);
    check("ifg_done_busy", 16'(out_busy), 16'h0);

    // Continuous requests on generators 1 and 3.
    restart();
    in_valid = 8'h05;
    step();
    for (int f = 0; f < 4; f++) begin
`ifdef TSN_ARB_RR_EN
      exp_g = (f % 2 == 0) ? 8'h01 : 8'h04;
`else
      exp_g = 8'h01;
`endif
      check("seq_grant", 16'(out_grant), 16'(exp_g));
      check("seq_sel",   16'(out_sel),   (exp_g == 8'h01) ? 16'h0 : 16'h2);
      idle_cycles(19);
      in_tx_done = 1'b1;
      step();
      in_tx_done = 1'b0;
      gap = 0;
      while (out_grant == '0 && gap < 40) begin
        gap++;
        step();
      end
      check("seq_gap", 16'(gap), 16'd13);
    end

    // Guard band: slot_cnt 799 still grants.
    restart();
    in_valid = 8'h00;
    in_slot_shift = 1'b1;
    step();
    in_slot_shift = 1'b0;
    idle_cycles(799);
    in_valid = 8'h02;
    step();
    check("guard799_grant", 16'(out_grant), 16'h02);
    in_valid = 8'h00;
    in_tx_done = 1'b1;
    step();
    in_tx_done = 1'b0;
    idle_cycles(15);

    // slot_cnt 800 blocks until the next boundary pulse.
    in_slot_shift = 1'b1;
    step();
    in_slot_shift = 1'b0;
    idle_cycles(800);
    in_valid = 8'h02;
    step();
    check("guard800_grant", 16'(out_grant), 16'h00);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (out_grant != '0) seen = 1'b1;
    end
    check("guard_hold_off", 16'(seen), 16'h0);
    in_slot_shift = 1'b1;
    step();
    in_slot_shift = 1'b0;
    check("shift_grant", 16'(out_grant), 16'h02);

    // Abort while BUSY, then re-enable.
    in_test_start = 1'b0;
    step();
    in_test_start = 1'b1;
    check("abort_grant", 16'(out_grant), 16'h00);
    check("abort_busy",  16'(out_busy),  16'h0);
    in_valid = 8'h00;
    idle_cycles(799);
    in_valid = 8'h05;
    step();
    check("reen_grant", 16'(out_grant), 16'h01);

    // Asynchronous reset in the middle of the gap.
    in_valid = 8'h00;
    in_tx_done = 1'b1;
    step();
    in_tx_done = 1'b0;
    idle_cycles(3);
    check("ifg_busy", 16'(out_busy), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 16'(out_grant), 16'h00);
    check("arst_sel",   16'(out_sel),   16'h0);
    check("arst_busy",  16'(out_busy),  16'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tsn_tx_arbiter.md
# tsn_tx_arbiter

Transmit arbiter for the TSN NIC traffic path. It sits between the gate control module's 8-bit gated-valid vector and the shared transmit datapath. It grants exactly one traffic generator at a time, holds the grant until that frame completes, and enforces an inter-frame gap. It also enforces a guard band before each slot boundary so that no frame starts too late to finish inside its slot.

## Interface
Parameters:
- `PLATFORM`, "xilinx", target vendor tag; no functional effect.
- `SLOT_CYCLES`, 1000, slot length in clk cycles (1..65535).
- `GUARD_CYCLES`, 200, cycles at the end of each slot in which no new grant is issued (0..SLOT_CYCLES).
- `IFG_CYCLES`, 12, idle cycles after a frame ends before the next grant (0..255).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_test_start`  in  1  level; 0 = arbiter disabled and synchronously cleared.
- `in_slot_shift`  in  1  single-cycle pulse marking a slot boundary.
- `in_valid`  in  8  gated requests; bit i = generator i+1 eligible this cycle.
- `in_tx_done`  in  1  single-cycle pulse on the last cycle of the granted frame.
- `out_grant`  out  8  registered one-hot grant; 0 = no grant.
- `out_sel`  out  3  registered index of the granted generator; valid while `out_grant` != 0.
- `out_busy`  out  1  registered; 1 in BUSY or IFG.

## Operation
- Reset values: `out_grant`=0, `out_sel`=0, `out_busy`=0, state=IDLE, `slot_cnt`=0, `ifg_cnt`=0, `rr_ptr`=7.
- Slot counter `slot_cnt`, 16 bits:
  - Cleared to 0 when `in_slot_shift`=1.
  - Otherwise increments each cycle and saturates at 0xFFFF.
- Guard condition: `guard` = `slot_cnt` >= (SLOT_CYCLES − GUARD_CYCLES), evaluated on the registered `slot_cnt`. `guard` is forced to 0 in any cycle where `in_slot_shift`=1.
- State machine:
  - **IDLE**: if `in_test_start` & !`guard` & |`in_valid`:
    - Pick winner w, set `out_grant`=1<<w, `out_sel`=w, `out_busy`=1.
    - Set `rr_ptr`=w (round-robin build only).
    - Go to BUSY.
    - `in_tx_done` is ignored in IDLE.
  - **BUSY**: hold the grant regardless of `in_valid` (a gate closing mid-frame does not abort the frame). On `in_tx_done`:
    - Clear `out_grant`.
    - If IFG_CYCLES=0, go to IDLE with `out_busy`=0.
    - Otherwise load `ifg_cnt`=IFG_CYCLES−1 and go to IFG.
  - **IFG**: decrement `ifg_cnt`. When `ifg_cnt`=0, go to IDLE and clear `out_busy`.
- `in_test_start`=0, in any state, has priority over everything else. Next cycle:
  - State=IDLE, `out_grant`=0, `out_busy`=0, `ifg_cnt`=0, `slot_cnt`=0, `rr_ptr`=7.
  - Any in-flight grant is dropped.
- A slot boundary during BUSY or IFG does not affect the grant; it only restarts `slot_cnt`.
- Winner selection is defined in Configuration.

## Timing
- Grant latency: `in_valid` asserted in cycle N while in IDLE and not in guard → `out_grant` valid at N+1.
- Release: `in_tx_done` in cycle M → `out_grant`=0 at M+1.
- Earliest next grant:
  - IFG_CYCLES>0: at M+IFG_CYCLES+2 (IDLE reached at M+IFG_CYCLES+1, grant registered one cycle later).
  - IFG_CYCLES=0: at M+2.
- Back-to-back frames therefore leave at least one grant-free cycle.
- Guard boundary: with SLOT_CYCLES=1000 and GUARD_CYCLES=200:
  - A request while `slot_cnt`=799 is granted.
  - A request while `slot_cnt`=800 is not granted.
- GUARD_CYCLES=SLOT_CYCLES blocks all grants except in cycles where `in_slot_shift`=1.

## Configuration
- Macro `TSN_ARB_RR_EN`.
- Defined: round-robin. The search starts at index (`rr_ptr`+1) mod 8, wraps, and takes the first set bit of `in_valid`. `rr_ptr` holds the last winner.
- Undefined: strict priority. The lowest set bit of `in_valid` wins (generator 1 highest). The `rr_ptr` register is not built.

## Test plan
- After reset, hold `in_test_start`=1 and `in_valid`=8'h00 → `out_grant`=0 and `out_busy`=0 indefinitely. Then `in_valid`=8'h04 → `out_grant`=8'h04 and `out_sel`=2 one cycle later.
- `in_valid`=8'h05 constant, with a `in_tx_done` pulse 20 cycles after each grant, IFG_CYCLES=12:
  - RR build: grants alternate 8'h01, 8'h04, 8'h01, …
  - Strict build: grants are always 8'h01.
  - In both builds, the gap between a `in_tx_done` pulse and the next grant is exactly 13 cycles.
- Guard band: `in_slot_shift` pulse, then request at `slot_cnt`=800 → no grant. Next `in_slot_shift` → grant one cycle after that pulse.
- Gate closes mid-frame: `in_valid` drops to 0 while in BUSY → grant held until `in_tx_done`, then released.
- Abort: drop `in_test_start` while in BUSY → `out_grant`=0 and `out_busy`=0 next cycle. Re-enable → `slot_cnt` restarts from 0 and the RR search starts at index 0.
- Assert `rst_n`=0 asynchronously mid-IFG → all outputs 0 immediately, with no clock edge required.
